// File: rtl/switch_debounce_pkg.sv
// Shared widths and default timing for the switch/button conditioning block.
// Pulled in by switch_debounce and switch_debounce_bit.
package switch_debounce_pkg;

   localparam int SW_WIDTH              = 8;
   localparam int DEBOUNCE_TICK_DIV     = 100000;
   localparam int DEBOUNCE_STABLE_TICKS = 10;

   // Sized so that STABLE_TICKS-1 always fits, including STABLE_TICKS=1.
   function automatic int cnt_width(input int stable_ticks);
      return $clog2(stable_ticks) + 1;
   endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One debounced input: 2-FF synchroniser, mismatch counter and stable level.
// The counter advances only on the shared sample tick.
module switch_debounce_bit
   import switch_debounce_pkg::*;
#(
   parameter int STABLE_TICKS = DEBOUNCE_STABLE_TICKS
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic din,
   output logic stable
);

   localparam int            CW       = cnt_width(STABLE_TICKS);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

   logic          sync_q1;
   logic          sync_q2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
         cnt     <= '0;
         stable  <= 1'b0;
      end else begin
         sync_q1 <= din;
         sync_q2 <= sync_q1;
         if (tick) begin
            // Any tick that sees the current level again discards the run.
            if (sync_q2 == stable) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               stable <= sync_q2;
               cnt    <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/switch_debounce.sv
// Board slide-switch and confirm-button conditioner feeding the memorio switch latch.
// Define SW_CHANGE_FLAG_EN to add the sticky sw_flag with its flag_clr input.
module switch_debounce
   import switch_debounce_pkg::*;
#(
   parameter int N_SW         = SW_WIDTH,
   parameter int TICK_DIV     = DEBOUNCE_TICK_DIV,
   parameter int STABLE_TICKS = DEBOUNCE_STABLE_TICKS
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_SW-1:0] sw_in,
   input  logic            btn_in,
`ifdef SW_CHANGE_FLAG_EN
   input  logic            flag_clr,
   output logic            sw_flag,
`endif
   output logic [N_SW-1:0] sw_stable,
   output logic            sw_changed,
   output logic            btn_press
);

   localparam int            TW        = $clog2(TICK_DIV);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   logic [TW-1:0]   tick_cnt;
   logic            tick;
   logic            btn_stable;
   logic            btn_prev;
   logic [N_SW-1:0] sw_prev;

   assign tick = (tick_cnt == TICK_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + TW'(1);
      end
   end

   for (genvar i = 0; i < N_SW; i++) begin : g_sw
      switch_debounce_bit #(
         .STABLE_TICKS (STABLE_TICKS)
      ) u_bit (
         .clk    (clk),
         .rst_n  (rst_n),
         .tick   (tick),
         .din    (sw_in[i]),
         .stable (sw_stable[i])
      );
   end

   switch_debounce_bit #(
      .STABLE_TICKS (STABLE_TICKS)
   ) u_btn (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (tick),
      .din    (btn_in),
      .stable (btn_stable)
   );

   // Delayed copies give pulses one cycle after the debounced levels move.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_prev    <= '0;
         btn_prev   <= 1'b0;
         sw_changed <= 1'b0;
         btn_press  <= 1'b0;
      end else begin
         sw_prev    <= sw_stable;
         btn_prev   <= btn_stable;
         sw_changed <= |(sw_stable ^ sw_prev);
         btn_press  <= btn_stable & ~btn_prev;
      end
   end

`ifdef SW_CHANGE_FLAG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_flag <= 1'b0;
      end else if (sw_changed) begin
         sw_flag <= 1'b1;
      end else if (flag_clr) begin
         sw_flag <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce with TICK_DIV=4, STABLE_TICKS=3.
// Expected levels are queued when inputs change and popped on each output pulse.
module tb_switch_debounce;

   localparam int N_SW = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N_SW-1:0] sw_in = '0;
   logic            btn_in = 1'b0;
   logic [N_SW-1:0] sw_stable;
   logic            sw_changed;
   logic            btn_press;
`ifdef SW_CHANGE_FLAG_EN
   logic            flag_clr = 1'b0;
   logic            sw_flag;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int sw_pulses = 0;
   int btn_pulses = 0;

   logic [N_SW-1:0] sw_q[$];
   bit              btn_q[$];

   switch_debounce #(
      .N_SW         (N_SW),
      .TICK_DIV     (4),
      .STABLE_TICKS (3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sw_in      (sw_in),
      .btn_in     (btn_in),
`ifdef SW_CHANGE_FLAG_EN
      .flag_clr   (flag_clr),
      .sw_flag    (sw_flag),
`endif
      .sw_stable  (sw_stable),
      .sw_changed (sw_changed),
      .btn_press  (btn_press)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Output side of the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         if (sw_changed) begin
            sw_pulses++;
            if (sw_q.size() == 0) chk("sw_unexpected_pulse", 32'(sw_stable), 32'hDEAD);
            else chk("sw_level", 32'(sw_stable), 32'(sw_q.pop_front()));
         end
         if (btn_press) begin
            btn_pulses++;
            if (btn_q.size() == 0) chk("btn_unexpected_pulse", 1, 0);
            else chk("btn_press", 1, 32'(btn_q.pop_front()));
         end
      end
   end

   task automatic drain(input string tag, input int max_cyc);
      int k = 0;
      while ((sw_q.size() != 0 || btn_q.size() != 0) && k < max_cyc) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      chk(tag, sw_q.size() + btn_q.size(), 0);
   endtask

   initial begin
      int p0;
      int b0;
      // 1: reset with everything pressed, then release
      sw_in  = 8'hFF;
      btn_in = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_sw_stable", 32'(sw_stable), 0);
      chk("rst_sw_changed", 32'(sw_changed), 0);
      chk("rst_btn_press", 32'(btn_press), 0);
`ifdef SW_CHANGE_FLAG_EN
      chk("rst_sw_flag", 32'(sw_flag), 0);
`endif
      sw_q.push_back(8'hFF);
      btn_q.push_back(1'b1);
      rst_n = 1'b1;
      repeat (11) @(negedge clk);
      chk("t1_before_3rd_tick", 32'(sw_stable), 0);
      @(negedge clk);
      chk("t1_at_3rd_tick", 32'(sw_stable), 32'hFF);
      drain("t1_drain", 10);

      // 2: clean changes, bounded latency, one pulse each
      btn_in = 1'b0;
      sw_in  = 8'h00;
      sw_q.push_back(8'h00);
      drain("t2_to_00", 20);
      p0 = sw_pulses;
      sw_in = 8'hA5;
      sw_q.push_back(8'hA5);
      drain("t2_to_A5", 16);
      repeat (20) @(negedge clk);
      chk("t2_one_pulse", sw_pulses - p0, 1);
      chk("t2_level", 32'(sw_stable), 32'hA5);

      // 3: bounce on bit0 must not reach the output
      sw_in = 8'hA4;
      sw_q.push_back(8'hA4);
      drain("t3_to_A4", 16);
      p0 = sw_pulses;
      for (int i = 0; i < 8; i++) begin
         sw_in[0] = ~i[0];
         repeat (5) @(negedge clk);
      end
      chk("t3_no_pulse_bounce", sw_pulses - p0, 0);
      chk("t3_level_bounce", 32'(sw_stable), 32'hA4);
      sw_in[0] = 1'b1;
      sw_q.push_back(8'hA5);
      drain("t3_settle", 16);
      chk("t3_one_pulse", sw_pulses - p0, 1);

      // 4: long button hold, then release
      b0 = btn_pulses;
      btn_q.push_back(1'b1);
      btn_in = 1'b1;
      repeat (80) @(negedge clk);
      chk("t4_hold_pulses", btn_pulses - b0, 1);
      btn_in = 1'b0;
      repeat (30) @(negedge clk);
      chk("t4_release_pulses", btn_pulses - b0, 1);

      // 5: reset in the middle of a count
      sw_in = 8'h5A;
      repeat (10) @(negedge clk);
      chk("t5_two_ticks", 32'(sw_stable), 32'hA5);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t5_rst_level", 32'(sw_stable), 0);
      chk("t5_rst_pulse", 32'(sw_changed), 0);
      repeat (2) @(negedge clk);
      sw_q.push_back(8'h5A);
      rst_n = 1'b1;
      repeat (11) @(negedge clk);
      chk("t5_before_3rd_tick", 32'(sw_stable), 0);
      @(negedge clk);
      chk("t5_at_3rd_tick", 32'(sw_stable), 32'h5A);
      drain("t5_drain", 10);

`ifdef SW_CHANGE_FLAG_EN
      // 6: sticky flag, set beats clear
      begin
         bit seen = 1'b0;
         chk("t6_flag_set", 32'(sw_flag), 1);
         repeat (10) @(negedge clk);
         chk("t6_flag_hold", 32'(sw_flag), 1);
         flag_clr = 1'b1;
         @(negedge clk);
         flag_clr = 1'b0;
         chk("t6_flag_clr", 32'(sw_flag), 0);
         sw_in = 8'h00;
         sw_q.push_back(8'h00);
         for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (sw_changed) seen = 1'b1;
         end
         chk("t6_pulse_seen", 32'(seen), 1);
         flag_clr = 1'b1;
         @(negedge clk);
         flag_clr = 1'b0;
         chk("t6_set_wins", 32'(sw_flag), 1);
         drain("t6_drain", 10);
      end
`endif

      repeat (5) @(negedge clk);
      chk("end_queues_empty", sw_q.size() + btn_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
